// File: rtl/cfs_algn_pkg.sv
// Shared types and helpers for the aligner core: default bus geometry, byte/offset/size
// types and the (offset,size) legality rule used for both rx chunks and ctrl settings.
package cfs_algn_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_B          = DEF_DATA_WIDTH / 8;

  typedef logic [7:0]                   byte_t;
  typedef logic [$clog2(DEF_B)-1:0]     offset_t;
  typedef logic [$clog2(DEF_B):0]       size_t;

  // A chunk is legal when it carries at least one byte and does not run past lane B-1.
  function automatic logic chunk_legal(input int offset, input int size, input int nbytes);
    return (size >= 1) && (offset + size <= nbytes);
  endfunction

endpackage

// File: rtl/cfs_algn_byte_buf.sv
// 2B-byte FIFO-ordered shift buffer: shifts out consumed head bytes, then appends a
// lane range of the incoming word at the tail, in one cycle.
module cfs_algn_byte_buf
  import cfs_algn_pkg::*;
#(
  parameter  int unsigned B  = DEF_B,
  localparam int unsigned OW = $clog2(B),
  localparam int unsigned SW = $clog2(B) + 1,
  localparam int unsigned LW = SW + 1,
  localparam int unsigned IW = $clog2(2 * B)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic [SW-1:0] shift_cnt_i,
  input  logic          app_en_i,
  input  logic [8*B-1:0] app_data_i,
  input  logic [OW-1:0] app_off_i,
  input  logic [SW-1:0] app_size_i,
  output logic [8*B-1:0] head_o,
  output logic [LW-1:0] lvl_o
);

  byte_t         mem_q [2*B];
  byte_t         mem_d [2*B];
  byte_t         app_bytes [B];
  logic [LW-1:0] lvl_q, lvl_d;

  always_comb begin
    for (int k = 0; k < B; k++) app_bytes[k] = app_data_i[8*k +: 8];
  end

  // Shift first, then append behind the post-shift level.
  // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
  always_comb begin
    int            sh;
    int            lvl_s;
    logic [IW-1:0] idx;
    logic [OW-1:0] lane;
    sh    = int'(shift_cnt_i);
    lvl_s = int'(lvl_q) - sh;
    idx   = '0;
    lane  = '0;
    for (int i = 0; i < 2 * B; i++) begin
      mem_d[i] = 8'h00;
      if (i + sh < 2 * B) begin
        idx      = IW'(i + sh);
        mem_d[i] = mem_q[idx];
      end
      if (app_en_i && (i >= lvl_s) && (i < lvl_s + int'(app_size_i))) begin
        lane     = OW'(int'(app_off_i) + i - lvl_s);
        mem_d[i] = app_bytes[lane];
      end
    end
    lvl_d = LW'(lvl_s + (app_en_i ? int'(app_size_i) : 0));
    if (clr_i) lvl_d = '0;
  end

  // NOTE: the byte storage is reset along with the level so nothing downstream can ever see X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lvl_q <= '0;
      for (int i = 0; i < 2 * B; i++) mem_q[i] <= 8'h00;
    end else begin
      lvl_q <= lvl_d;
      mem_q <= mem_d;
    end
  end

  always_comb begin
    head_o = '0;
    for (int k = 0; k < B; k++) head_o[8*k +: 8] = mem_q[k];
  end

  assign lvl_o = lvl_q;

endmodule

// File: rtl/cfs_algn_core.sv
// Byte realigner: accumulates variable rx chunks in order and emits ctrl_size-byte
// chunks placed at ctrl_offset; holds the output register and load/flow control.
module cfs_algn_core
  import cfs_algn_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  localparam int unsigned B            = DATA_WIDTH / 8,
  localparam int unsigned OFFSET_WIDTH = $clog2(B),
  localparam int unsigned SIZE_WIDTH   = $clog2(B) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    rx_valid,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic [OFFSET_WIDTH-1:0] rx_offset,
  input  logic [SIZE_WIDTH-1:0]   rx_size,
  output logic                    rx_ready,
  output logic                    tx_valid,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic [OFFSET_WIDTH-1:0] tx_offset,
  output logic [SIZE_WIDTH-1:0]   tx_size,
  input  logic                    tx_ready,
  input  logic [OFFSET_WIDTH-1:0] ctrl_offset,
  input  logic [SIZE_WIDTH-1:0]   ctrl_size,
  input  logic                    clr,
  output logic [SIZE_WIDTH:0]     buf_lvl,
  output logic                    busy,
  output logic                    err_illegal
);

  logic                    cfg_legal, rx_legal;
  logic                    load, rx_acc, append;
  logic [DATA_WIDTH-1:0]   head;
  byte_t                   head_bytes [B];
  logic [DATA_WIDTH-1:0]   tx_data_d;
  logic [SIZE_WIDTH-1:0]   shift_cnt;

  logic                    tx_valid_q;
  logic [DATA_WIDTH-1:0]   tx_data_q;
  logic [OFFSET_WIDTH-1:0] tx_offset_q;
  logic [SIZE_WIDTH-1:0]   tx_size_q;
  logic                    err_q;

  assign cfg_legal = chunk_legal(int'(ctrl_offset), int'(ctrl_size), int'(B));
  assign rx_legal  = chunk_legal(int'(rx_offset), int'(rx_size), int'(B));

  // Load when the output register is free or draining this cycle; clr wins over load.
  assign load = cfg_legal && !clr && (int'(buf_lvl) >= int'(ctrl_size)) &&
                (!tx_valid_q || tx_ready);

  // Room for a full B-byte chunk after this cycle's load; deliberately ignores rx_* inputs.
  assign rx_ready  = (int'(buf_lvl) - (load ? int'(ctrl_size) : 0)) <= int'(B);
  assign rx_acc    = rx_valid && rx_ready;
  assign append    = rx_acc && rx_legal && !clr;
  assign shift_cnt = load ? ctrl_size : '0;

  cfs_algn_byte_buf #(.B(B)) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .clr_i      (clr),
    .shift_cnt_i(shift_cnt),
    .app_en_i   (append),
    .app_data_i (rx_data),
    .app_off_i  (rx_offset),
    .app_size_i (rx_size),
    .head_o     (head),
    .lvl_o      (buf_lvl)
  );

  always_comb begin
    for (int k = 0; k < B; k++) head_bytes[k] = head[8*k +: 8];
  end

  // Oldest ctrl_size bytes land in lanes ctrl_offset.. ascending; other lanes stay zero.
  always_comb begin
    logic [OFFSET_WIDTH-1:0] idx;
    idx       = '0;
    tx_data_d = '0;
    for (int l = 0; l < B; l++) begin
      if ((l >= int'(ctrl_offset)) && (l < int'(ctrl_offset) + int'(ctrl_size))) begin
        idx                  = OFFSET_WIDTH'(l - int'(ctrl_offset));
        tx_data_d[8*l +: 8]  = head_bytes[idx];
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      tx_offset_q <= '0;
      tx_size_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      err_q <= rx_acc && !rx_legal;
      if (load) begin
        tx_valid_q  <= 1'b1;
        tx_data_q   <= tx_data_d;
        tx_offset_q <= ctrl_offset;
        tx_size_q   <= ctrl_size;
      end else if (tx_ready) begin
        tx_valid_q  <= 1'b0;
      end
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign tx_offset   = tx_offset_q;
  assign tx_size     = tx_size_q;
  assign err_illegal = err_q;
  assign busy        = (buf_lvl != '0) || tx_valid_q;

endmodule

// File: tb/tb_cfs_algn_core.sv
// Self-checking bench for cfs_algn_core: directed scenarios plus randomized traffic
// checked against a byte-queue reference model.
module tb_cfs_algn_core;

  logic        clk, reset_n;
  logic        rx_valid, rx_ready, tx_valid, tx_ready, clr, busy, err_illegal;
  logic [31:0] rx_data, tx_data;
  logic [1:0]  rx_offset, tx_offset, ctrl_offset;
  logic [2:0]  rx_size, tx_size, ctrl_size;
  logic [3:0]  buf_lvl;

  int n_vec = 0;
  int n_err = 0;

  // Per-step observations
  logic        rx_hs, tx_hs, s_rdy, s_tv, s_err;
  logic [31:0] s_td;
  logic [1:0]  s_to;
  logic [2:0]  s_ts;
  logic [3:0]  s_lvl;

  cfs_algn_core #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_offset(rx_offset), .rx_size(rx_size),
    .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_offset(tx_offset), .tx_size(tx_size),
    .tx_ready(tx_ready),
    .ctrl_offset(ctrl_offset), .ctrl_size(ctrl_size), .clr(clr),
    .buf_lvl(buf_lvl), .busy(busy), .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle: sample registered state, drive inputs, then sample handshakes.
  task automatic step(input logic rv, input logic [31:0] d, input logic [1:0] o,
                      input logic [2:0] s, input logic tr, input logic c);
    @(negedge clk);
    s_err = err_illegal;
    s_lvl = buf_lvl;
    rx_valid = rv; rx_data = d; rx_offset = o; rx_size = s; tx_ready = tr; clr = c;
    #1;
    s_rdy = rx_ready;
    s_tv  = tx_valid;
    s_td  = tx_data;
    s_to  = tx_offset;
    s_ts  = tx_size;
    rx_hs = rv && rx_ready;
    tx_hs = tx_valid && tr;
  endtask

  task automatic idle(input logic tr);
    step(1'b0, 32'h0, 2'd0, 3'd0, tr, 1'b0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx_valid = 0; rx_data = 0; rx_offset = 0; rx_size = 0; tx_ready = 0; clr = 0;
    ctrl_offset = 0; ctrl_size = 3'd4;
    #3;
    n_vec++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b exp 0", tx_valid); end
    n_vec++; if (tx_data !== 32'h0) begin n_err++; $display("FAIL reset_tx_data: got %h exp 0", tx_data); end
    n_vec++; if (buf_lvl !== 4'd0) begin n_err++; $display("FAIL reset_buf_lvl: got %0d exp 0", buf_lvl); end
    n_vec++; if ({tx_offset, tx_size, busy, err_illegal} !== 7'd0) begin n_err++;
      $display("FAIL reset_misc: got off=%0d size=%0d busy=%b err=%b exp all 0", tx_offset, tx_size, busy, err_illegal); end
    n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready: got %b exp 1", rx_ready); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_bytewise();
    logic got;
    ctrl_offset = 2'd0; ctrl_size = 3'd4;
    step(1'b1, 32'h0000_0011, 2'd0, 3'd1, 1'b1, 1'b0);
    n_vec++; if (rx_hs !== 1'b1) begin n_err++; $display("FAIL bytewise_accept: got %b exp 1", rx_hs); end
    step(1'b1, 32'h0000_2200, 2'd1, 3'd1, 1'b1, 1'b0);
    step(1'b1, 32'h0033_0000, 2'd2, 3'd1, 1'b1, 1'b0);
    step(1'b1, 32'h4400_0000, 2'd3, 3'd1, 1'b1, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      idle(1'b1);
      if (tx_hs) begin
        got = 1'b1;
        n_vec++; if (s_td !== 32'h4433_2211) begin n_err++; $display("FAIL bytewise_data: got %h exp 44332211", s_td); end
        n_vec++; if ({s_to, s_ts} !== {2'd0, 3'd4}) begin n_err++; $display("FAIL bytewise_fmt: got off=%0d size=%0d exp 0/4", s_to, s_ts); end
      end
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL bytewise_timeout: got no tx exp one tx"); end
    idle(1'b1);
    n_vec++; if ({s_tv, s_lvl} !== 5'd0) begin n_err++; $display("FAIL bytewise_idle: got tv=%b lvl=%0d exp 0/0", s_tv, s_lvl); end
  endtask

  task automatic test_split();
    ctrl_offset = 2'd1; ctrl_size = 3'd2;
    step(1'b1, 32'hDDCC_BBAA, 2'd0, 3'd4, 1'b1, 1'b0);
    n_vec++; if (rx_hs !== 1'b1) begin n_err++; $display("FAIL split_accept: got %b exp 1", rx_hs); end
    idle(1'b1);
    n_vec++; if (s_tv !== 1'b0) begin n_err++; $display("FAIL split_latency: got tv=%b at t+1 exp 0", s_tv); end
    idle(1'b1);
    n_vec++; if (!tx_hs || s_td !== 32'h00BB_AA00 || s_to !== 2'd1 || s_ts !== 3'd2) begin n_err++;
      $display("FAIL split_first: got tv=%b %h off=%0d size=%0d exp 1 00bbaa00 1/2", s_tv, s_td, s_to, s_ts); end
    idle(1'b1);
    n_vec++; if (!tx_hs || s_td !== 32'h00DD_CC00) begin n_err++;
      $display("FAIL split_second: got tv=%b %h exp 1 00ddcc00", s_tv, s_td); end
    idle(1'b1);
    n_vec++; if ({s_tv, s_lvl} !== 5'd0) begin n_err++; $display("FAIL split_idle: got tv=%b lvl=%0d exp 0/0", s_tv, s_lvl); end
  endtask

  task automatic test_backpressure();
    logic [31:0] c [3];
    int acc;
    ctrl_offset = 2'd0; ctrl_size = 3'd4;
    for (int i = 0; i < 3; i++) c[i] = $urandom;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, (acc < 3) ? c[acc] : 32'hDEAD_BEEF, 2'd0, 3'd4, 1'b0, 1'b0);
      if (rx_hs) acc++;
    end
    n_vec++; if (acc !== 3) begin n_err++; $display("FAIL bp_accepted: got %0d exp 3", acc); end
    n_vec++; if (s_lvl !== 4'd8 || s_rdy !== 1'b0) begin n_err++;
      $display("FAIL bp_full: got lvl=%0d rdy=%b exp 8/0", s_lvl, s_rdy); end
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      if (i == 0) begin
        n_vec++; if (s_rdy !== 1'b1) begin n_err++; $display("FAIL bp_ready_return: got %b exp 1", s_rdy); end
      end
      n_vec++; if (!tx_hs || s_td !== c[i]) begin n_err++;
        $display("FAIL bp_drain%0d: got tv=%b %h exp 1 %h", i, s_tv, s_td, c[i]); end
    end
    idle(1'b1);
    n_vec++; if ({s_tv, s_lvl} !== 5'd0) begin n_err++; $display("FAIL bp_idle: got tv=%b lvl=%0d exp 0/0", s_tv, s_lvl); end
  endtask

  task automatic test_illegal_rx();
    ctrl_offset = 2'd0; ctrl_size = 3'd4;
    step(1'b1, $urandom, 2'd0, 3'd0, 1'b1, 1'b0);
    n_vec++; if (rx_hs !== 1'b1 || s_err !== 1'b0) begin n_err++;
      $display("FAIL illrx_size0: got hs=%b err=%b exp 1/0", rx_hs, s_err); end
    step(1'b1, $urandom, 2'd3, 3'd2, 1'b1, 1'b0);
    n_vec++; if (rx_hs !== 1'b1 || s_err !== 1'b1) begin n_err++;
      $display("FAIL illrx_over: got hs=%b err=%b exp 1/1", rx_hs, s_err); end
    idle(1'b1);
    n_vec++; if (s_err !== 1'b1 || s_lvl !== 4'd0) begin n_err++;
      $display("FAIL illrx_second_pulse: got err=%b lvl=%0d exp 1/0", s_err, s_lvl); end
    idle(1'b1);
    n_vec++; if ({s_err, s_tv, s_lvl} !== 6'd0) begin n_err++;
      $display("FAIL illrx_quiet: got err=%b tv=%b lvl=%0d exp 0/0/0", s_err, s_tv, s_lvl); end
  endtask

  task automatic test_illegal_cfg();
    logic any_tv;
    ctrl_offset = 2'd0; ctrl_size = 3'd0;
    any_tv = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, $urandom, 2'd0, 3'd4, 1'b1, 1'b0);
      any_tv |= s_tv;
    end
    idle(1'b1);
    any_tv |= s_tv;
    n_vec++; if (s_lvl !== 4'd8 || s_rdy !== 1'b0 || busy !== 1'b1) begin n_err++;
      $display("FAIL illcfg_full: got lvl=%0d rdy=%b busy=%b exp 8/0/1", s_lvl, s_rdy, busy); end
    n_vec++; if (any_tv !== 1'b0) begin n_err++; $display("FAIL illcfg_no_tx: got tx_valid seen exp none"); end
    step(1'b0, 32'h0, 2'd0, 3'd0, 1'b1, 1'b1);
    idle(1'b1);
    n_vec++; if (s_lvl !== 4'd0 || busy !== 1'b0) begin n_err++;
      $display("FAIL illcfg_clr: got lvl=%0d busy=%b exp 0/0", s_lvl, busy); end
  endtask

  // Reference: every legal accepted chunk appends its bytes to a queue; every tx handshake
  // must carry the next ctrl_size queued bytes at ctrl_offset. Bytes still queued are
  // either in the buffer or in the pending output word.
  task automatic test_random(input int n_steps);
    logic [7:0]  q [$];
    logic [31:0] d, exp_w, prev_td;
    logic [1:0]  o;
    logic [2:0]  s;
    logic        rv, tr, prev_ill, prev_stall, legal;
    int          sz, off, n_tx;
    sz  = $urandom_range(1, 4);
    off = $urandom_range(0, 4 - sz);
    ctrl_size = 3'(sz); ctrl_offset = 2'(off);
    prev_ill = 1'b0; prev_stall = 1'b0; prev_td = '0; n_tx = 0;
    for (int t = 0; t < n_steps + 12; t++) begin
      d  = $urandom;
      rv = (t < n_steps) && ($urandom_range(0, 3) != 0);
      tr = (t >= n_steps) || ($urandom_range(0, 2) != 0);
      o  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) s = 3'($urandom_range(0, 4));
      else                           s = 3'($urandom_range(1, 4 - int'(o)));
      step(rv, d, o, s, tr, 1'b0);
      n_vec++; if (s_err !== prev_ill) begin n_err++;
        $display("FAIL rand_err t=%0d: got %b exp %b", t, s_err, prev_ill); end
      n_vec++; if (int'(s_lvl) + (s_tv ? sz : 0) !== q.size()) begin n_err++;
        $display("FAIL rand_level t=%0d: got lvl=%0d tv=%b exp %0d bytes held", t, s_lvl, s_tv, q.size()); end
      if (prev_stall) begin
        n_vec++; if (s_tv !== 1'b1 || s_td !== prev_td) begin n_err++;
          $display("FAIL rand_stable t=%0d: got tv=%b %h exp 1 %h", t, s_tv, s_td, prev_td); end
      end
      if (tx_hs) begin
        exp_w = '0;
        for (int k = 0; k < sz; k++) exp_w = exp_w | (32'(q.pop_front()) << (8 * (off + k)));
        n_tx++;
        n_vec++; if (s_td !== exp_w || int'(s_to) !== off || int'(s_ts) !== sz) begin n_err++;
          $display("FAIL rand_tx%0d: got %h off=%0d size=%0d exp %h off=%0d size=%0d", n_tx, s_td, s_to, s_ts, exp_w, off, sz); end
      end
      legal = (int'(s) >= 1) && (int'(o) + int'(s) <= 4);
      if (rx_hs && legal)
        for (int k = 0; k < int'(s); k++) q.push_back(8'(d >> (8 * (int'(o) + k))));
      prev_ill   = rx_hs && !legal;
      prev_stall = s_tv && !tr;
      prev_td    = s_td;
    end
    idle(1'b1);
    n_vec++; if (s_tv !== 1'b0 || int'(s_lvl) !== q.size() || int'(s_lvl) >= sz) begin n_err++;
      $display("FAIL rand_drain: got tv=%b lvl=%0d exp 0 and %0d (< %0d)", s_tv, s_lvl, q.size(), sz); end
    n_vec++; if (n_tx == 0) begin n_err++; $display("FAIL rand_activity: got 0 tx exp some"); end
    step(1'b0, 32'h0, 2'd0, 3'd0, 1'b1, 1'b1);
    idle(1'b1);
  endtask

  task automatic test_reset_mid();
    ctrl_offset = 2'd0; ctrl_size = 3'd4;
    step(1'b1, $urandom, 2'd0, 3'd4, 1'b0, 1'b0);
    step(1'b1, $urandom, 2'd0, 3'd3, 1'b0, 1'b0);
    @(negedge clk);
    n_vec++; if (buf_lvl !== 4'd3 || tx_valid !== 1'b1) begin n_err++;
      $display("FAIL rstmid_pre: got lvl=%0d tv=%b exp 3/1", buf_lvl, tx_valid); end
    rx_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    n_vec++; if ({tx_valid, tx_data, tx_offset, tx_size, buf_lvl, busy, err_illegal} !== 44'd0) begin n_err++;
      $display("FAIL rstmid_state: got tv=%b %h off=%0d size=%0d lvl=%0d busy=%b err=%b exp all 0",
               tx_valid, tx_data, tx_offset, tx_size, buf_lvl, busy, err_illegal); end
    n_vec++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_rx_ready: got %b exp 1", rx_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    idle(1'b1);
    n_vec++; if ({s_tv, s_lvl} !== 5'd0) begin n_err++; $display("FAIL rstmid_after: got tv=%b lvl=%0d exp 0/0", s_tv, s_lvl); end
  endtask

  initial begin
    test_reset();
    test_bytewise();
    test_split();
    test_backpressure();
    test_illegal_rx();
    test_illegal_cfg();
    for (int r = 0; r < 4; r++) test_random(300);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
